regfile_writeback: RTL and testbench

Writeback-side consumer of the MEM/WB pipeline register in the RV32I pipelined core. It selects the final result (ALU result, load data or PC+4) and commits it to the 32-entry integer register file. It serves the two decode-stage read ports with same-cycle write-through bypass. It also keeps a retired-instruction counter. It takes the registered W-stage control and data fields directly and closes the loop back to decode.

---
 rtl/regfile_writeback.sv | 93 +++++++++
 tb/tb_regfile_writeback.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Writeback result select, 32 x XLEN integer register file with write-through read bypass, retire counter.
// Latency: reads/ResultW combinational, writes and InstRetW one edge; backpressure: none, always accepts.
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcW,
    input  logic [XLEN-1:0]  ALUResultW,
    input  logic [XLEN-1:0]  ReadDataW,
    input  logic [XLEN-1:0]  PCPlus4W,
    input  logic [4:0]       RdW,
    input  logic             ValidW,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    output logic [XLEN-1:0]  RD1D,
    output logic [XLEN-1:0]  RD2D,
    output logic [XLEN-1:0]  ResultW,
    output logic [CNT_W-1:0] InstRetW
);

    logic [XLEN-1:0]  regs_q [0:31];
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;
    logic             wr_en;

    always_comb begin
        ResultW = '0;
        case (ResultSrcW)
            2'b00:   ResultW = ALUResultW;
            2'b01:   ResultW = ReadDataW;
            2'b10:   ResultW = PCPlus4W;
            default: ResultW = '0;
        endcase
    end

    // Entry 0 is never written, and reads of index 0 are forced to zero,
    // so x0 collapses to a constant.
    assign wr_en = RegWriteW && (RdW != 5'd0);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[RdW] <= ResultW;
        end
    end

    always_comb begin
        RD1D = '0;
        if (Rs1D == 5'd0) begin
            RD1D = '0;
        end else if (RegWriteW && (RdW == Rs1D)) begin
            RD1D = ResultW;
        end else begin
            RD1D = regs_q[Rs1D];
        end
    end

    always_comb begin
        RD2D = '0;
        if (Rs2D == 5'd0) begin
            RD2D = '0;
        end else if (RegWriteW && (RdW == Rs2D)) begin
            RD2D = ResultW;
        end else begin
            RD2D = regs_q[Rs2D];
        end
    end

    // Retirement is independent of RegWriteW: stores and branches count too.
    always_comb begin
        instret_d = instret_q;
        if (ValidW) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign InstRetW = instret_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a default build plus a CNT_W=4 build sharing stimulus for wrap checks.
module tb_regfile_writeback;

    logic        i_clk;
    logic        i_rstn;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic        ValidW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [31:0] RD1D, RD2D, ResultW;
    logic [63:0] InstRetW;
    logic [31:0] RD1D_s, RD2D_s, ResultW_s;
    logic [3:0]  InstRetW_s;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_writeback #(.XLEN(32), .CNT_W(64)) u_dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
        .ValidW(ValidW), .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D),
        .ResultW(ResultW), .InstRetW(InstRetW)
    );

    regfile_writeback #(.XLEN(32), .CNT_W(4)) u_dut_small (
        .i_clk(i_clk), .i_rstn(i_rstn), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
        .ValidW(ValidW), .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D_s), .RD2D(RD2D_s),
        .ResultW(ResultW_s), .InstRetW(InstRetW_s)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [12:0] vpat;

    initial begin
        i_rstn = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'b00; ALUResultW = '0;
        ReadDataW = '0; PCPlus4W = '0; RdW = '0; ValidW = 1'b0; Rs1D = '0; Rs2D = '0;

        // Activity during reset must be suppressed
        @(negedge i_clk);
        RegWriteW = 1'b1; RdW = 5'd10; ALUResultW = 32'h55; ValidW = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        RegWriteW = 1'b0; ValidW = 1'b0; RdW = '0; ALUResultW = '0;
        i_rstn = 1'b1;
        #1;
        chk("reset_instret", InstRetW, 64'd0);
        chk("reset_instret_small", {60'd0, InstRetW_s}, 64'd0);
        for (int r = 1; r < 32; r++) begin
            Rs1D = 5'(r); Rs2D = 5'(r);
            #1;
            chk("reset_rd1", {32'd0, RD1D}, 64'd0);
            chk("reset_rd2", {32'd0, RD2D}, 64'd0);
        end

        // Write x5, read it back next cycle
        @(negedge i_clk);
        RegWriteW = 1'b1; RdW = 5'd5; ResultSrcW = 2'b00; ALUResultW = 32'hDEADBEEF; ValidW = 1'b1;
        Rs1D = 5'd1; Rs2D = 5'd2;
        #1;
        chk("alu_result", {32'd0, ResultW}, {32'd0, 32'hDEADBEEF});
        @(negedge i_clk);
        RegWriteW = 1'b0; ValidW = 1'b0; Rs1D = 5'd5;
        #1;
        chk("wr_then_rd_x5", {32'd0, RD1D}, {32'd0, 32'hDEADBEEF});
        chk("instret_after_1", InstRetW, 64'd1);

        // Load-data bypass on port 2 in the write cycle
        @(negedge i_clk);
        RegWriteW = 1'b1; RdW = 5'd7; ResultSrcW = 2'b01; ReadDataW = 32'h0000_00A5;
        ALUResultW = 32'h1111_1111; ValidW = 1'b1; Rs1D = 5'd5; Rs2D = 5'd7;
        #1;
        chk("bypass_rd2_load", {32'd0, RD2D}, {32'd0, 32'h0000_00A5});
        chk("no_bypass_rd1", {32'd0, RD1D}, {32'd0, 32'hDEADBEEF});
        chk("load_result", {32'd0, ResultW}, {32'd0, 32'h0000_00A5});
        @(negedge i_clk);
        RegWriteW = 1'b0; ValidW = 1'b0;
        #1;
        chk("x7_stored", {32'd0, RD2D}, {32'd0, 32'h0000_00A5});
        chk("instret_after_2", InstRetW, 64'd2);

        // PC+4 select, with bubble (ValidW=0) still writing
        @(negedge i_clk);
        RegWriteW = 1'b1; RdW = 5'd8; ResultSrcW = 2'b10; PCPlus4W = 32'h0000_1004;
        ALUResultW = 32'h77; ValidW = 1'b0; Rs1D = 5'd8;
        #1;
        chk("pc4_result", {32'd0, ResultW}, {32'd0, 32'h0000_1004});
        chk("bypass_rd1_pc4", {32'd0, RD1D}, {32'd0, 32'h0000_1004});

        // Reserved select yields zero and the zero is written
        @(negedge i_clk);
        RegWriteW = 1'b1; RdW = 5'd9; ResultSrcW = 2'b11; ALUResultW = 32'hAAAA_AAAA;
        ReadDataW = 32'hBBBB_BBBB; PCPlus4W = 32'hCCCC_CCCC; Rs1D = 5'd8; Rs2D = 5'd9;
        #1;
        chk("rsv_result", {32'd0, ResultW}, 64'd0);
        chk("bubble_write_x8", {32'd0, RD1D}, {32'd0, 32'h0000_1004});
        chk("rsv_bypass_rd2", {32'd0, RD2D}, 64'd0);

        // Bypass requires RegWriteW; identical ports on Rs1D=Rs2D
        @(negedge i_clk);
        RegWriteW = 1'b0; RdW = 5'd5; ResultSrcW = 2'b00; ALUResultW = 32'h1111_1111;
        Rs1D = 5'd5; Rs2D = 5'd5;
        #1;
        chk("no_wen_no_bypass", {32'd0, RD1D}, {32'd0, 32'hDEADBEEF});
        chk("same_idx_rd2", {32'd0, RD2D}, {32'd0, 32'hDEADBEEF});
        Rs1D = 5'd9;
        #1;
        chk("x9_zero_stored", {32'd0, RD1D}, 64'd0);

        // x0 protection
        @(negedge i_clk);
        RegWriteW = 1'b1; RdW = 5'd0; ResultSrcW = 2'b00; ALUResultW = 32'hFFFF_FFFF;
        Rs1D = 5'd0; Rs2D = 5'd0;
        #1;
        chk("x0_same_cycle_rd1", {32'd0, RD1D}, 64'd0);
        chk("x0_same_cycle_rd2", {32'd0, RD2D}, 64'd0);
        chk("x0_result", {32'd0, ResultW}, {32'd0, 32'hFFFF_FFFF});
        @(negedge i_clk);
        RegWriteW = 1'b0;
        #1;
        chk("x0_later", {32'd0, RD1D}, 64'd0);

        // Async reset mid-run
        @(negedge i_clk);
        RegWriteW = 1'b1; RdW = 5'd3; ResultSrcW = 2'b00; ALUResultW = 32'h0000_1234; ValidW = 1'b1;
        @(negedge i_clk);
        RegWriteW = 1'b0; ValidW = 1'b0; Rs1D = 5'd3;
        #1;
        chk("x3_written", {32'd0, RD1D}, {32'd0, 32'h0000_1234});
        chk("instret_before_rst", InstRetW, 64'd3);
        RegWriteW = 1'b1; RdW = 5'd4; ALUResultW = 32'h99; ValidW = 1'b1; Rs2D = 5'd4;
        #1;
        i_rstn = 1'b0;
        #1;
        chk("async_rst_x3", {32'd0, RD1D}, 64'd0);
        chk("async_rst_instret", InstRetW, 64'd0);
        chk("rst_result_follows", {32'd0, ResultW}, {32'd0, 32'h99});
        chk("rst_bypass_rd2", {32'd0, RD2D}, {32'd0, 32'h99});
        @(negedge i_clk);
        RegWriteW = 1'b0; ValidW = 1'b0; i_rstn = 1'b1; Rs1D = 5'd4;
        #1;
        chk("rst_blocked_write_x4", {32'd0, RD1D}, 64'd0);
        chk("rst_blocked_count", InstRetW, 64'd0);

        // 10 retires with 3 bubbles interleaved
        vpat = 13'b1110111011011;
        for (int i = 0; i < 13; i++) begin
            @(negedge i_clk);
            ValidW = vpat[i];
        end
        @(negedge i_clk);
        ValidW = 1'b0;
        #1;
        chk("instret_10", InstRetW, 64'd10);
        chk("instret_small_10", {60'd0, InstRetW_s}, 64'd10);

        // Drive the 4-bit counter to 15, then wrap
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            ValidW = 1'b1;
        end
        @(negedge i_clk);
        ValidW = 1'b0;
        #1;
        chk("small_at_15", {60'd0, InstRetW_s}, 64'd15);
        @(negedge i_clk);
        ValidW = 1'b1;
        @(negedge i_clk);
        ValidW = 1'b0;
        #1;
        chk("small_wrap_0", {60'd0, InstRetW_s}, 64'd0);
        chk("wide_at_16", InstRetW, 64'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
